// File: rtl/sobel_window_if.sv
// Pixel-column stream into the Sobel stage and gradient-magnitude stream out of it.
// The master drives the three line taps and receives the magnitude.
// The slave is the Sobel stage itself.
interface sobel_window_if #(
   parameter int WIDTH = 8
);
   logic             ivalid;
   logic             sof;
   logic [WIDTH-1:0] tap_top;
   logic [WIDTH-1:0] tap_mid;
   logic [WIDTH-1:0] tap_bot;
   logic             ovalid;
   logic [WIDTH-1:0] omag;
   logic             oeof;

   modport master (
      output ivalid, sof, tap_top, tap_mid, tap_bot,
      input  ovalid, omag, oeof
   );

   modport slave (
      input  ivalid, sof, tap_top, tap_mid, tap_bot,
      output ovalid, omag, oeof
   );
endinterface

// File: rtl/sobel_window.sv
// 3x3 Sobel gradient-magnitude stage.
// Each accepted sample carries one pixel column: the current line and the two lines above it.
// Pipeline:
//   stage 1 shifts the window and tags the sample with its col/row/eof.
//   stage 2 forms Gx/Gy.
//   stage 3 forms the saturated |Gx|+|Gy|.
// An accepted sample therefore appears on the output after its third clock edge.
module sobel_window #(
   parameter int WIDTH     = 8,
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 480,
   parameter int SHIFT_OUT = 0
) (
   input logic           clock,
   input logic           reset,
   sobel_window_if.slave pix
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int GW = WIDTH + 3;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [GW-1:0] MAG_MAX  = GW'((1 << WIDTH) - 1);

   // Zero-extend a pixel into the signed gradient width.
   function automatic logic [GW-1:0] ext(input logic [WIDTH-1:0] v);
      ext = {3'b000, v};
   endfunction

   // ------------------------------------------------------------------
   // Position counters: they track the position of the next sample.
   // ------------------------------------------------------------------
   logic [CW-1:0] col_reg;
   logic [RW-1:0] row_reg;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          cur_eof;

   // Position of the sample on the taps now.
   // sof forces this sample to (0,0), so a sof sample can never also be end-of-frame.
   always_comb begin
      cur_col = pix.sof ? '0 : col_reg;
      cur_row = pix.sof ? '0 : row_reg;
      cur_eof = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
   end

   // Advance column/row raster order on each accepted sample.
   always_ff @(posedge clock) begin
      if (!reset) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (pix.ivalid) begin
         if (cur_col == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col_reg <= cur_col + CW'(1);
            row_reg <= cur_row;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: the 3x3 window.
   // p[r][c]: r=0 is the oldest line, c=2 is the newest column.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] tap [0:2];
   logic [WIDTH-1:0] p   [0:2][0:2];

   assign tap[0] = pix.tap_top;
   assign tap[1] = pix.tap_mid;
   assign tap[2] = pix.tap_bot;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         logic [WIDTH-1:0] px_reg [0:2];

         // Shift this window row one column older and load the new column pixel.
         // The row holds when no sample is accepted.
         always_ff @(posedge clock) begin
            if (!reset) begin
               px_reg[0] <= '0;
               px_reg[1] <= '0;
               px_reg[2] <= '0;
            end else if (pix.ivalid) begin
               px_reg[0] <= px_reg[1];
               px_reg[1] <= px_reg[2];
               px_reg[2] <= tap[gi];
            end
         end

         assign p[gi][0] = px_reg[0];
         assign p[gi][1] = px_reg[1];
         assign p[gi][2] = px_reg[2];
      end
   endgenerate

   logic          v1_reg;
   logic [CW-1:0] col1_reg;
   logic [RW-1:0] row1_reg;
   logic          eof1_reg;

   // Tag the sample that has just entered the window with its position.
   always_ff @(posedge clock) begin
      if (!reset) begin
         v1_reg   <= 1'b0;
         col1_reg <= '0;
         row1_reg <= '0;
         eof1_reg <= 1'b0;
      end else begin
         v1_reg <= pix.ivalid;
         if (pix.ivalid) begin
            col1_reg <= cur_col;
            row1_reg <= cur_row;
            eof1_reg <= cur_eof;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: Sobel kernels.
   // Every operand is non-negative, so each sum fits in GW bits.
   // The difference |G| <= 4*(2^WIDTH-1) also fits, as a signed GW-bit value.
   // ------------------------------------------------------------------
   logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [GW-1:0] gx_next, gy_next;
   logic                 border1;

   // Form the two gradients.
   // Also decide whether the window reaches outside the frame.
   always_comb begin
      gx_pos  = ext(p[0][2]) + (ext(p[1][2]) << 1) + ext(p[2][2]);
      gx_neg  = ext(p[0][0]) + (ext(p[1][0]) << 1) + ext(p[2][0]);
      gy_pos  = ext(p[2][0]) + (ext(p[2][1]) << 1) + ext(p[2][2]);
      gy_neg  = ext(p[0][0]) + (ext(p[0][1]) << 1) + ext(p[0][2]);
      gx_next = signed'(gx_pos - gx_neg);
      gy_next = signed'(gy_pos - gy_neg);
      border1 = (col1_reg < COL_TWO) || (row1_reg < ROW_TWO);
   end

   logic                 v2_reg;
   logic signed [GW-1:0] gx_reg;
   logic signed [GW-1:0] gy_reg;
   logic                 border2_reg;
   logic                 eof2_reg;

   // Register the gradients together with the sample's border and eof flags.
   always_ff @(posedge clock) begin
      if (!reset) begin
         v2_reg      <= 1'b0;
         gx_reg      <= '0;
         gy_reg      <= '0;
         border2_reg <= 1'b0;
         eof2_reg    <= 1'b0;
      end else begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            gx_reg      <= gx_next;
            gy_reg      <= gy_next;
            border2_reg <= border1;
            eof2_reg    <= eof1_reg;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: magnitude, scaling and saturation.
   // ------------------------------------------------------------------
   logic [GW-1:0]    abs_gx, abs_gy, mag_sum, mag_shift;
   logic [WIDTH-1:0] mag_next;

   // Compute L1 magnitude, scale it down, then clamp it to the pixel range.
   // Windows that are not yet complete output 0.
   always_comb begin
      abs_gx    = gx_reg[GW-1] ? unsigned'(-gx_reg) : unsigned'(gx_reg);
      abs_gy    = gy_reg[GW-1] ? unsigned'(-gy_reg) : unsigned'(gy_reg);
      mag_sum   = abs_gx + abs_gy;
      mag_shift = mag_sum >> SHIFT_OUT;
      mag_next  = '0;
      if (!border2_reg) begin
         mag_next = (mag_shift > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : mag_shift[WIDTH-1:0];
      end
   end

   logic             ovalid_reg;
   logic [WIDTH-1:0] omag_reg;
   logic             oeof_reg;

   // Output register.
   // ovalid pulses once per sample; omag/oeof hold between pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ovalid_reg <= 1'b0;
         omag_reg   <= '0;
         oeof_reg   <= 1'b0;
      end else begin
         ovalid_reg <= v2_reg;
         if (v2_reg) begin
            omag_reg <= mag_next;
            oeof_reg <= eof2_reg;
         end
      end
   end

   assign pix.ovalid = ovalid_reg;
   assign pix.omag   = omag_reg;
   assign pix.oeof   = oeof_reg;

endmodule

// File: tb/tb_sobel_window.sv
// Self-checking bench for sobel_window with an 8x6 frame.
// Two instances share one stimulus stream: one with SHIFT_OUT=0, one with SHIFT_OUT=2.
// Expected outputs come from the frame image itself.
// For each sample, the model takes its raster position and evaluates the Sobel sums over the
// image neighbourhood.
module tb_sobel_window;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int PW = 8;

   logic clock;
   logic reset;
   logic ivalid;
   logic sof;
   logic [PW-1:0] tap_top, tap_mid, tap_bot;

   sobel_window_if #(.WIDTH(PW)) if0 ();
   sobel_window_if #(.WIDTH(PW)) if2 ();

   assign if0.ivalid  = ivalid;
   assign if0.sof     = sof;
   assign if0.tap_top = tap_top;
   assign if0.tap_mid = tap_mid;
   assign if0.tap_bot = tap_bot;
   assign if2.ivalid  = ivalid;
   assign if2.sof     = sof;
   assign if2.tap_top = tap_top;
   assign if2.tap_mid = tap_mid;
   assign if2.tap_bot = tap_bot;

   sobel_window #(.WIDTH(PW), .IMG_W(W), .IMG_H(H), .SHIFT_OUT(0)) u_dut0 (
      .clock (clock),
      .reset (reset),
      .pix   (if0)
   );

   sobel_window #(.WIDTH(PW), .IMG_W(W), .IMG_H(H), .SHIFT_OUT(2)) u_dut2 (
      .clock (clock),
      .reset (reset),
      .pix   (if2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int img [0:H-1][0:W-1];
   int cap0 [0:H-1][0:W-1];
   int cap2 [0:H-1][0:W-1];
   int out_cnt = 0;
   int eof_cnt = 0;
   int dr = 0, dc = 0;   // driver raster position
   int mr = 0, mc = 0;   // model raster position

   typedef struct {
      int due;
      int r;
      int c;
      int m0;
      int m2;
      int eof;
   } exp_t;
   exp_t expq [$];

   typedef struct {
      int kind;   // image the vector applies to: 1 vertical step, 2 bright pixel
      int r;
      int c;
      int m0;
      int m2;
   } vec_t;
   localparam int NV = 15;
   vec_t vecs [0:NV-1];

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sobel magnitude of the window ending at (r,c), from the image.
   function automatic int exp_mag(input int r, input int c, input int sh);
      int w [0:2][0:2];
      int gx, gy, m;
      if (r < 2 || c < 2) return 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[i][j] = img[r-2+i][c-2+j];
      gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
      gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
      m  = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> sh;
      return (m > 255) ? 255 : m;
   endfunction

   // Model: every accepted sample predicts one output, due after two more edges.
   always @(posedge clock) begin
      int   r, c;
      exp_t e;
      cyc <= cyc + 1;
      if (!reset) begin
         mr <= 0;
         mc <= 0;
         expq.delete();
      end else if (ivalid) begin
         r = sof ? 0 : mr;
         c = sof ? 0 : mc;
         e.due = cyc + 3;
         e.r   = r;
         e.c   = c;
         e.m0  = exp_mag(r, c, 0);
         e.m2  = exp_mag(r, c, 2);
         e.eof = (r == H-1 && c == W-1) ? 1 : 0;
         expq.push_back(e);
         if (c == W-1) begin
            mc <= 0;
            mr <= (r == H-1) ? 0 : r + 1;
         end else begin
            mc <= c + 1;
            mr <= r;
         end
      end
   end

   // Monitor: match every ovalid pulse against the oldest prediction.
   always @(negedge clock) begin
      exp_t e;
      if (if0.ovalid === 1'b1) begin
         if (expq.size() == 0) begin
            chk("spurious_ovalid", 1, 0);
         end else begin
            e = expq.pop_front();
            chk($sformatf("latency_r%0dc%0d", e.r, e.c), cyc, e.due);
            chk($sformatf("omag_s0_r%0dc%0d", e.r, e.c), int'(if0.omag), e.m0);
            chk($sformatf("omag_s2_r%0dc%0d", e.r, e.c), int'(if2.omag), e.m2);
            chk($sformatf("oeof_r%0dc%0d", e.r, e.c), int'(if0.oeof), e.eof);
            cap0[e.r][e.c] = int'(if0.omag);
            cap2[e.r][e.c] = int'(if2.omag);
            out_cnt++;
            if (if0.oeof === 1'b1) eof_cnt++;
         end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
         e = expq.pop_front();
         chk($sformatf("missing_ovalid_r%0dc%0d", e.r, e.c), 0, 1);
      end
      if (if0.ovalid === 1'b1 || if2.ovalid === 1'b1)
         chk("ovalid_s2_vs_s0", int'(if2.ovalid), int'(if0.ovalid));
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_img(input int kind);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            case (kind)
               0:       img[r][c] = 100;
               1:       img[r][c] = (c >= 4) ? 200 : 0;
               2:       img[r][c] = (r == 1 && c == 1) ? 255 : 0;
               default: img[r][c] = int'($urandom_range(255, 0));
            endcase
            cap0[r][c] = -1;
            cap2[r][c] = -1;
         end
   endtask

   // Drive n samples in raster order from the image.
   // Up to gmax idle cycles go before each sample; sof is set on sample sof_at.
   task automatic send(input int n, input int gmax, input int sof_at);
      int r, c;
      for (int i = 0; i < n; i++) begin
         int g;
         g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
         for (int k = 0; k < g; k++) begin
            ivalid = 1'b0;
            sof    = 1'b0;
            tick();
         end
         r = (i == sof_at) ? 0 : dr;
         c = (i == sof_at) ? 0 : dc;
         tap_bot = PW'(img[r][c]);
         tap_mid = (r >= 1) ? PW'(img[r-1][c]) : PW'($urandom);
         tap_top = (r >= 2) ? PW'(img[r-2][c]) : PW'($urandom);
         sof     = (i == sof_at);
         ivalid  = 1'b1;
         tick();
         if (c == W-1) begin
            dc = 0;
            dr = (r == H-1) ? 0 : r + 1;
         end else begin
            dc = c + 1;
            dr = r;
         end
      end
      ivalid = 1'b0;
      sof    = 1'b0;
   endtask

   task automatic drain;
      repeat (6) tick();
      chk("pending_outputs", expq.size(), 0);
   endtask

   task automatic check_table(input int kind);
      for (int i = 0; i < NV; i++)
         if (vecs[i].kind == kind) begin
            chk($sformatf("tbl%0d_s0_r%0dc%0d", kind, vecs[i].r, vecs[i].c),
                cap0[vecs[i].r][vecs[i].c], vecs[i].m0);
            chk($sformatf("tbl%0d_s2_r%0dc%0d", kind, vecs[i].r, vecs[i].c),
                cap2[vecs[i].r][vecs[i].c], vecs[i].m2);
         end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      // Vertical step at col 4: interior samples at col 4 and 5 give Gx=800.
      vecs[0]  = '{1, 2, 4, 255, 200};
      vecs[1]  = '{1, 2, 5, 255, 200};
      vecs[2]  = '{1, 4, 5, 255, 200};
      vecs[3]  = '{1, 5, 4, 255, 200};
      vecs[4]  = '{1, 3, 3,   0,   0};
      vecs[5]  = '{1, 3, 6,   0,   0};
      vecs[6]  = '{1, 1, 4,   0,   0};
      vecs[7]  = '{1, 3, 1,   0,   0};
      // Bright pixel at (1,1).
      // For sample (2,2) it is the window centre, which carries no weight, so the result is 0.
      // For sample (3,3) it lands on p00, giving Gx=Gy=-255.
      vecs[8]  = '{2, 2, 2,   0,   0};
      vecs[9]  = '{2, 3, 3, 255, 127};
      vecs[10] = '{2, 3, 2, 255, 127};
      vecs[11] = '{2, 2, 3, 255, 127};
      vecs[12] = '{2, 1, 1,   0,   0};
      vecs[13] = '{2, 4, 4,   0,   0};
      vecs[14] = '{2, 0, 1,   0,   0};

      // Reset with ivalid high: outputs stay at zero.
      reset = 1'b0; ivalid = 1'b1; sof = 1'b0;
      tap_top = '0; tap_mid = '0; tap_bot = '0;
      set_img(0);
      for (int i = 0; i < 4; i++) begin
         tap_top = PW'($urandom); tap_mid = PW'($urandom); tap_bot = PW'($urandom);
         @(negedge clock);
         chk("reset_ovalid", int'(if0.ovalid), 0);
         chk("reset_omag", int'(if0.omag), 0);
         chk("reset_oeof", int'(if0.oeof), 0);
         @(posedge clock);
         #1;
      end
      reset = 1'b1; ivalid = 1'b0;
      @(negedge clock);
      chk("post_reset_ovalid", int'(if0.ovalid), 0);
      chk("post_reset_omag", int'(if0.omag), 0);
      chk("post_reset_oeof", int'(if0.oeof), 0);
      tick();

      // Flat frame.
      set_img(0); out_cnt = 0; eof_cnt = 0;
      send(48, 0, -1); drain();
      chk("flat_out_count", out_cnt, 48);
      chk("flat_eof_count", eof_cnt, 1);

      // Vertical step, contiguous, then with idle gaps.
      set_img(1); out_cnt = 0; eof_cnt = 0;
      send(48, 0, -1); drain();
      check_table(1);
      chk("vstep_eof_count", eof_cnt, 1);
      set_img(1); out_cnt = 0;
      send(48, 3, -1); drain();
      check_table(1);
      chk("vstep_gap_out_count", out_cnt, 48);

      // Single bright pixel.
      set_img(2);
      send(48, 0, -1); drain();
      check_table(2);

      // Random frames with gaps.
      for (int f = 0; f < 3; f++) begin
         set_img(3); out_cnt = 0;
         send(48, 2, -1); drain();
         chk("rand_out_count", out_cnt, 48);
      end

      // sof on sample 13, then the rest of a frame from that point.
      set_img(3); eof_cnt = 0;
      send(61, 1, 13); drain();
      chk("sof_eof_count", eof_cnt, 1);

      // Reset mid-frame discards in-flight samples; the next sample is (0,0).
      set_img(3);
      send(20, 0, -1);
      reset = 1'b0; tick(); tick();
      reset = 1'b1; dr = 0; dc = 0;
      set_img(3); out_cnt = 0; eof_cnt = 0;
      send(48, 1, -1); drain();
      chk("midreset_out_count", out_cnt, 48);
      chk("midreset_eof_count", eof_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
